// File: rtl/riscv_ex_mem_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ex_mem_reg_if
//  Description : Bundle of the EX->MEM pipeline register handshake and
//                payload signals.
//                  EX side  : i_EX_valid / o_EX_ready plus EX payload
//                  MEM side : o_MEM_valid / i_MEM_ready plus head payload
//                  control  : i_flush (branch/jump redirect kill)
//                The slave modport is the pipeline register itself. The
//                master modport is whoever drives EX and consumes MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_ex_mem_reg_if #(
  parameter int XLEN = 32
);
  // EX-side handshake and payload
  logic            i_EX_valid;
  logic            o_EX_ready;
  logic [XLEN-1:0] i_EX_alu_out;
  logic [XLEN-1:0] i_EX_fwd_b;
  logic [XLEN-1:0] i_EX_pcimm;
  logic [XLEN-1:0] i_EX_pc4;
  logic [1:0]      i_EX_src_pc;
  logic            i_EX_reg_wr_en;
  logic            i_EX_mem_wr_en;
  logic [1:0]      i_EX_src_rd;
  logic [2:0]      i_EX_funct3;
  logic [4:0]      i_EX_rd;

  // Redirect kill
  logic            i_flush;

  // MEM-side handshake and head payload
  logic            o_MEM_valid;
  logic            i_MEM_ready;
  logic [XLEN-1:0] o_MEM_alu_out;
  logic [XLEN-1:0] o_MEM_fwd_b;
  logic [XLEN-1:0] o_MEM_pcimm;
  logic [XLEN-1:0] o_MEM_pc4;
  logic [1:0]      o_MEM_src_pc;
  logic            o_MEM_reg_wr_en;
  logic            o_MEM_mem_wr_en;
  logic [1:0]      o_MEM_src_rd;
  logic [2:0]      o_MEM_funct3;
  logic [4:0]      o_MEM_rd;
  logic [XLEN-1:0] o_MEM_fwd_alu_out;

  modport slave (
    input  i_EX_valid, i_EX_alu_out, i_EX_fwd_b, i_EX_pcimm, i_EX_pc4,
           i_EX_src_pc, i_EX_reg_wr_en, i_EX_mem_wr_en, i_EX_src_rd,
           i_EX_funct3, i_EX_rd, i_flush, i_MEM_ready,
    output o_EX_ready, o_MEM_valid, o_MEM_alu_out, o_MEM_fwd_b, o_MEM_pcimm,
           o_MEM_pc4, o_MEM_src_pc, o_MEM_reg_wr_en, o_MEM_mem_wr_en,
           o_MEM_src_rd, o_MEM_funct3, o_MEM_rd, o_MEM_fwd_alu_out
  );

  modport master (
    output i_EX_valid, i_EX_alu_out, i_EX_fwd_b, i_EX_pcimm, i_EX_pc4,
           i_EX_src_pc, i_EX_reg_wr_en, i_EX_mem_wr_en, i_EX_src_rd,
           i_EX_funct3, i_EX_rd, i_flush, i_MEM_ready,
    input  o_EX_ready, o_MEM_valid, o_MEM_alu_out, o_MEM_fwd_b, o_MEM_pcimm,
           o_MEM_pc4, o_MEM_src_pc, o_MEM_reg_wr_en, o_MEM_mem_wr_en,
           o_MEM_src_rd, o_MEM_funct3, o_MEM_rd, o_MEM_fwd_alu_out
  );
endinterface
`default_nettype wire

// File: rtl/riscv_ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ex_mem_reg
//  Description : Elastic EX->MEM pipeline register with a 2-entry skid
//                buffer (main + skid). Gives full throughput, an upstream
//                ready taken straight from a flop, in-order delivery, and a
//                synchronous flush for redirects.
//  Ports       : i_clk  - clock, rising edge
//                i_rstn - asynchronous active-low reset
//                bus    - riscv_ex_mem_reg_if.slave (EX handshake/payload,
//                         i_flush, MEM handshake/payload, forwarding tap)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_ex_mem_reg #(
  parameter int XLEN = 32
) (
  input  wire logic          i_clk,
  input  wire logic          i_rstn,
  riscv_ex_mem_reg_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] pcimm;
    logic [XLEN-1:0] pc4;
    logic [1:0]      src_pc;
    logic            reg_wr_en;
    logic            mem_wr_en;
    logic [1:0]      src_rd;
    logic [2:0]      funct3;
    logic [4:0]      rd;
  } payload_t;

  payload_t w_ex_pl;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     m_valid_q, m_valid_d;
  logic     s_valid_q, s_valid_d;
  logic     w_push;
  logic     w_pop;

  assign w_ex_pl = '{
    alu_out:   bus.i_EX_alu_out,
    fwd_b:     bus.i_EX_fwd_b,
    pcimm:     bus.i_EX_pcimm,
    pc4:       bus.i_EX_pc4,
    src_pc:    bus.i_EX_src_pc,
    reg_wr_en: bus.i_EX_reg_wr_en,
    mem_wr_en: bus.i_EX_mem_wr_en,
    src_rd:    bus.i_EX_src_rd,
    funct3:    bus.i_EX_funct3,
    rd:        bus.i_EX_rd
  };

  // Ready is the inverse of the skid flop only, so it never has a
  // combinational path from i_MEM_ready.
  assign w_push = bus.i_EX_valid & ~s_valid_q;
  assign w_pop  = m_valid_q & bus.i_MEM_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    main_d    = main_q;
    skid_d    = skid_q;
    if (bus.i_flush) begin
      // Kill everything held plus this cycle's transfer. A pop this cycle
      // was still taken by MEM, which needs no action here.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // FULL: ready is low, so only a pop can happen.
      if (w_pop) begin
        main_d    = skid_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      // ONE
      if (w_push && w_pop) begin
        main_d = w_ex_pl;
      end else if (w_push) begin
        skid_d    = w_ex_pl;
        s_valid_d = 1'b1;
      end else if (w_pop) begin
        m_valid_d = 1'b0;
      end
    end else if (w_push) begin
      // EMPTY
      main_d    = w_ex_pl;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
    end
  end

  assign bus.o_EX_ready        = ~s_valid_q;
  assign bus.o_MEM_valid       = m_valid_q;
  assign bus.o_MEM_alu_out     = main_q.alu_out;
  assign bus.o_MEM_fwd_b       = main_q.fwd_b;
  assign bus.o_MEM_pcimm       = main_q.pcimm;
  assign bus.o_MEM_pc4         = main_q.pc4;
  assign bus.o_MEM_src_pc      = main_q.src_pc;
  assign bus.o_MEM_src_rd      = main_q.src_rd;
  assign bus.o_MEM_funct3      = main_q.funct3;
  assign bus.o_MEM_rd          = main_q.rd;
  // Stale payload may linger after pop/flush; gating the write enables keeps
  // it from ever touching architectural state.
  assign bus.o_MEM_reg_wr_en   = m_valid_q & main_q.reg_wr_en;
  assign bus.o_MEM_mem_wr_en   = m_valid_q & main_q.mem_wr_en;
  assign bus.o_MEM_fwd_alu_out = main_q.alu_out;

endmodule
`default_nettype wire
